jt1943_prom_we: RTL

// - Download-side write steering between the MiST frame's ioctl byte stream and the SDRAM programming port.
// - Buffers each ioctl byte and maps it to a 16-bit-word SDRAM write (prog_*) or to a one-hot on-chip PROM write (prom_*).
// - Drives the prog_addr/prog_data/prog_mask/prog_we bus consumed by the frame's SDRAM loader during downloading.

---
 rtl/jt1943_prom_we.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/jt1943_prom_we.sv
// rtl/jt1943_prom_we.sv - steers ioctl download bytes to the SDRAM prog port or on-chip PROMs
// Optional JT1943_PROM_CSUM_EN adds csum[15:0], a wrap-around sum of accepted bytes.
module jt1943_prom_we #(
  parameter logic [21:0] PROM_START = 22'h3_C000,
  parameter int          NPROM      = 12,
  parameter int          FIFO_DW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             downloading,
  input  logic [21:0]      ioctl_addr,
  input  logic [7:0]       ioctl_data,
  input  logic             ioctl_wr,
  input  logic             sdram_ack,
  output logic [21:0]      prog_addr,
  output logic [7:0]       prog_data,
  output logic [1:0]       prog_mask,
  output logic             prog_we,
  output logic [NPROM-1:0] prom_we,
  output logic [7:0]       prom_addr,
  output logic [7:0]       prom_data,
  output logic             done,
  output logic             overflow
`ifdef JT1943_PROM_CSUM_EN
  ,
  output logic [15:0]      csum
`endif
);

  localparam int PW = (FIFO_DW > 1) ? $clog2(FIFO_DW) : 1;
  localparam int CW = $clog2(FIFO_DW) + 1;
  localparam logic [22:0] PROM_END = {1'b0, PROM_START} + 23'(256 * NPROM);

  typedef enum logic [1:0] {ST_IDLE, ST_SDWR, ST_GAP} state_t;

  state_t            state_q;
  logic [29:0]       mem_q [FIFO_DW];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [21:0]       prog_addr_q;
  logic [7:0]        prog_data_q;
  logic [1:0]        prog_mask_q;
  logic              prog_we_q;
  logic [NPROM-1:0]  prom_we_q;
  logic [7:0]        prom_addr_q, prom_data_q;
  logic              overflow_q, overflow_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;

  logic              empty, full, push, pop;
  logic [21:0]       h_addr, off;
  logic [7:0]        h_data;
  logic              in_sdram, in_prom;
  logic [NPROM-1:0]  prom_sel;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DW - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DW));
  assign {h_addr, h_data} = mem_q[rd_ptr_q];
  assign off      = h_addr - PROM_START;
  assign in_sdram = (h_addr < PROM_START);
  assign in_prom  = !in_sdram && ({1'b0, h_addr} < PROM_END);

  // PROM and out-of-range heads leave at once; an SDRAM head stays until acked
  assign pop  = ((state_q == ST_IDLE) && !empty && !in_sdram) ||
                ((state_q == ST_SDWR) && sdram_ack);
  assign push = ioctl_wr && downloading && (!full || pop);

  always_comb begin
    prom_sel = '0;
    for (int i = 0; i < NPROM; i++) prom_sel[i] = (off[21:8] == 14'(i));
  end

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q || (ioctl_wr && downloading && full && !pop);
    done_d     = armed_q && !downloading && empty && (state_q == ST_IDLE);
    armed_d    = downloading || (armed_q && !done_d);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ioctl_addr, ioctl_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= 2'b11;
      prog_we_q   <= 1'b0;
      prom_we_q   <= '0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
    end else begin
      prom_we_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            if (in_sdram) begin
              prog_addr_q <= {1'b0, h_addr[21:1]};
              prog_data_q <= h_data;
              prog_mask_q <= h_addr[0] ? 2'b01 : 2'b10;
              prog_we_q   <= 1'b1;
              state_q     <= ST_SDWR;
            end else if (in_prom) begin
              prom_we_q   <= prom_sel;
              prom_addr_q <= off[7:0];
              prom_data_q <= h_data;
            end
          end
        end
        ST_SDWR: begin
          if (sdram_ack) begin
            prog_we_q   <= 1'b0;
            prog_mask_q <= 2'b11;
            state_q     <= ST_GAP;
          end
        end
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef JT1943_PROM_CSUM_EN
  logic        dl_q;
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (downloading && !dl_q) csum_d = '0;
    if (push) csum_d = csum_d + {8'd0, ioctl_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q   <= 1'b0;
      csum_q <= '0;
    end else begin
      dl_q   <= downloading;
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign prog_mask = prog_mask_q;
  assign prog_we   = prog_we_q;
  assign prom_we   = prom_we_q;
  assign prom_addr = prom_addr_q;
  assign prom_data = prom_data_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule
